// File: rtl/project_pkg.sv
// Shared types and constants for the CPU system blocks.
package project_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} e_arb_state;

   localparam int ARB_BURST_MAX = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin owner of the single-port RAM: port 0 CPU data, port 1 loader; grant 1 cycle after
// a request from idle, rdata 1 cycle after a read grant; a held req waits, bursts cap at BURST_MAX.
module mem_arbiter
   import project_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int BURST_MAX = ARB_BURST_MAX
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int                CNT_W   = $clog2(BURST_MAX) + 1;
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BURST_MAX);

   e_arb_state       state_q;
   logic [CNT_W-1:0] beat_cnt_q;
   logic [CNT_W-1:0] beat_cnt_d;
   logic             last_q;
   logic             rvalid0_q;
   logic             rvalid1_q;
   logic             burst_done;

   // Grants are gated by reset so no beat (and no RAM write) can slip through a reset cycle.
   assign gnt0 = rst & (state_q == ARB_OWN0) & req0;
   assign gnt1 = rst & (state_q == ARB_OWN1) & req1;

   // Saturating count of the beat being taken this cycle.
   assign beat_cnt_d = (beat_cnt_q >= CNT_MAX) ? CNT_MAX : beat_cnt_q + CNT_W'(1);
   assign burst_done = (beat_cnt_d == CNT_MAX);

   assign mem_addr  = (state_q == ARB_OWN1) ? addr1  : addr0;
   assign mem_wdata = (state_q == ARB_OWN1) ? wdata1 : wdata0;
   assign mem_we    = (gnt0 & we0) | (gnt1 & we1);

   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata   = mem_rdata;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ARB_IDLE;
         beat_cnt_q <= '0;
         last_q     <= 1'b1;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
      end else begin
         rvalid0_q <= gnt0 & ~we0;
         rvalid1_q <= gnt1 & ~we1;
         case (state_q)
            ARB_IDLE: begin
               if (req0 && (!req1 || last_q)) begin
                  state_q <= ARB_OWN0;
               end else if (req1) begin
                  state_q <= ARB_OWN1;
               end
            end
            ARB_OWN0: begin
               if (!req0) begin
                  state_q    <= req1 ? ARB_OWN1 : ARB_IDLE;
                  beat_cnt_q <= '0;
                  last_q     <= 1'b0;
               end else if (burst_done && req1) begin
                  state_q    <= ARB_OWN1;
                  beat_cnt_q <= '0;
                  last_q     <= 1'b0;
               end else begin
                  beat_cnt_q <= beat_cnt_d;
               end
            end
            ARB_OWN1: begin
               if (!req1) begin
                  state_q    <= req0 ? ARB_OWN0 : ARB_IDLE;
                  beat_cnt_q <= '0;
                  last_q     <= 1'b1;
               end else if (burst_done && req0) begin
                  state_q    <= ARB_OWN0;
                  beat_cnt_q <= '0;
                  last_q     <= 1'b1;
               end else begin
                  beat_cnt_q <= beat_cnt_d;
               end
            end
            default: begin
               state_q    <= ARB_IDLE;
               beat_cnt_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM on the memory side.
module tb_mem_arbiter;
   import project_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, we0, req1, we1;
   logic [7:0] addr0, wdata0, addr1, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1, mem_we;
   logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic [7:0] ram [0:255];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .BURST_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req0 = 0; we0 = 0; addr0 = 8'h00; wdata0 = 8'h00;
      req1 = 0; we1 = 0; addr1 = 8'h00; wdata1 = 8'h00;
   endtask

   task automatic do_reset();
      rst = 0;
      clear_inputs();
      next_cycle();
      next_cycle();
      rst = 1;
   endtask

   task automatic test_reset();
      rst = 0;
      clear_inputs();
      req0 = 1; we0 = 1; addr0 = 8'h33; wdata0 = 8'h5A;
      for (int c = 0; c < 2; c++) begin
         next_cycle(); #1;
         n_checks++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0: got %b want 0", gnt0); end
         n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
      end
      n_checks++; if (dut.state_q !== ARB_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
      n_checks++; if (dut.beat_cnt_q !== 3'd0) begin n_fail++; $display("FAIL reset_beat_cnt: got %0d want 0", dut.beat_cnt_q); end
      n_checks++; if (dut.last_q !== 1'b1) begin n_fail++; $display("FAIL reset_last: got %b want 1", dut.last_q); end
      n_checks++; if ({rvalid0, rvalid1} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", {rvalid0, rvalid1}); end
      rst = 1; #1;
      n_checks++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL release_idle_gnt0: got %b want 0", gnt0); end
      next_cycle(); #1;
      n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL release_gnt0: got %b want 1", gnt0); end
      n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL release_mem_we: got %b want 1", mem_we); end
      n_checks++; if (mem_addr !== 8'h33) begin n_fail++; $display("FAIL release_addr: got %h want 33", mem_addr); end
      n_checks++; if (mem_wdata !== 8'h5A) begin n_fail++; $display("FAIL release_wdata: got %h want 5a", mem_wdata); end
      req0 = 0;
      next_cycle();
   endtask

   task automatic test_single_read();
      do_reset();
      req1 = 1; we1 = 1; addr1 = 8'h10; wdata1 = 8'hA5; #1;
      n_checks++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL sr_idle_gnt1: got %b want 0", gnt1); end
      next_cycle(); #1;
      n_checks++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL sr_wr_gnt1: got %b want 1", gnt1); end
      n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL sr_wr_mem_we: got %b want 1", mem_we); end
      n_checks++; if (mem_addr !== 8'h10) begin n_fail++; $display("FAIL sr_wr_addr: got %h want 10", mem_addr); end
      n_checks++; if (mem_wdata !== 8'hA5) begin n_fail++; $display("FAIL sr_wr_wdata: got %h want a5", mem_wdata); end
      next_cycle();
      we1 = 0; #1;
      n_checks++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL sr_rd_gnt1: got %b want 1", gnt1); end
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL sr_rd_mem_we: got %b want 0", mem_we); end
      next_cycle();
      req1 = 0; #1;
      n_checks++; if (rvalid1 !== 1'b1) begin n_fail++; $display("FAIL sr_rvalid1: got %b want 1", rvalid1); end
      n_checks++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL sr_rdata: got %h want a5", rdata); end
      n_checks++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL sr_rvalid0: got %b want 0", rvalid0); end
      next_cycle(); #1;
      n_checks++; if (rvalid1 !== 1'b0) begin n_fail++; $display("FAIL sr_rvalid1_end: got %b want 0", rvalid1); end
   endtask

   task automatic test_tie();
      do_reset();
      req0 = 1; req1 = 1; addr0 = 8'h10; addr1 = 8'h20; #1;
      n_checks++; if ({gnt0, gnt1} !== 2'b00) begin n_fail++; $display("FAIL tie_idle: got %b want 00", {gnt0, gnt1}); end
      for (int k = 1; k <= 4; k++) begin
         next_cycle(); #1;
         n_checks++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL tie_beat%0d: got %b want 10", k, {gnt0, gnt1}); end
      end
      next_cycle(); #1;
      n_checks++; if ({gnt0, gnt1} !== 2'b01) begin n_fail++; $display("FAIL tie_handover: got %b want 01", {gnt0, gnt1}); end
      n_checks++; if (mem_addr !== 8'h20) begin n_fail++; $display("FAIL tie_addr: got %h want 20", mem_addr); end
      n_checks++; if (dut.last_q !== 1'b0) begin n_fail++; $display("FAIL tie_last: got %b want 0", dut.last_q); end
      clear_inputs();
      next_cycle();
   endtask

   task automatic test_fairness();
      int cnt0, cnt1, run, max_run;
      logic prev0;
      cnt0 = 0; cnt1 = 0; run = 0; max_run = 0; prev0 = 1'b0;
      do_reset();
      req0 = 1; req1 = 1;
      next_cycle();
      for (int k = 0; k < 20; k++) begin
         #1;
         n_checks++;
         if ({gnt0, gnt1} !== (((k / 4) % 2 == 0) ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL fair_cycle%0d: got %b want %b", k, {gnt0, gnt1}, ((k / 4) % 2 == 0) ? 2'b10 : 2'b01);
         end
         if (gnt0) cnt0++;
         if (gnt1) cnt1++;
         run = (k != 0 && gnt0 == prev0) ? run + 1 : 1;
         if (run > max_run) max_run = run;
         prev0 = gnt0;
         next_cycle();
      end
      n_checks++; if (cnt0 != 12) begin n_fail++; $display("FAIL fair_cnt0: got %0d want 12", cnt0); end
      n_checks++; if (cnt1 != 8) begin n_fail++; $display("FAIL fair_cnt1: got %0d want 8", cnt1); end
      n_checks++; if (max_run > 4) begin n_fail++; $display("FAIL fair_max_burst: got %0d want <=4", max_run); end
      clear_inputs();
      next_cycle();
   endtask

   task automatic test_solo_burst();
      do_reset();
      req0 = 1; we0 = 1; addr0 = 8'h40; wdata0 = 8'h11;
      next_cycle();
      for (int k = 0; k < 10; k++) begin
         #1;
         n_checks++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL solo_beat%0d: got %b want 10", k, {gnt0, gnt1}); end
         n_checks++;
         if (dut.beat_cnt_q !== ((k < 4) ? k[2:0] : 3'd4)) begin
            n_fail++; $display("FAIL solo_cnt%0d: got %0d want %0d", k, dut.beat_cnt_q, (k < 4) ? k : 4);
         end
         next_cycle();
      end
      n_checks++; if (dut.state_q !== ARB_OWN0) begin n_fail++; $display("FAIL solo_state: got %0d want OWN0", dut.state_q); end
      n_checks++; if (dut.beat_cnt_q !== 3'd4) begin n_fail++; $display("FAIL solo_sat: got %0d want 4", dut.beat_cnt_q); end
      clear_inputs();
      next_cycle();
   endtask

   task automatic test_back_to_back();
      do_reset();
      req0 = 1; we0 = 0; addr0 = 8'h10;
      next_cycle(); #1;
      n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt0: got %b want 1", gnt0); end
      req1 = 1; we1 = 0; addr1 = 8'h20;
      next_cycle(); #1;
      n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt0_beat2: got %b want 1", gnt0); end
      n_checks++; if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid0: got %b want 1", rvalid0); end
      n_checks++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL b2b_rdata: got %h want a5", rdata); end
      n_checks++; if (rvalid1 !== 1'b0) begin n_fail++; $display("FAIL b2b_rvalid1: got %b want 0", rvalid1); end
      next_cycle();
      req0 = 0; #1;
      n_checks++; if ({gnt0, gnt1} !== 2'b00) begin n_fail++; $display("FAIL b2b_drop: got %b want 00", {gnt0, gnt1}); end
      next_cycle(); #1;
      n_checks++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt1: got %b want 1", gnt1); end
      n_checks++; if (mem_addr !== 8'h20) begin n_fail++; $display("FAIL b2b_addr1: got %h want 20", mem_addr); end
      n_checks++; if (dut.last_q !== 1'b0) begin n_fail++; $display("FAIL b2b_last0: got %b want 0", dut.last_q); end
      req1 = 0;
      next_cycle(); #1;
      n_checks++; if (dut.state_q !== ARB_IDLE) begin n_fail++; $display("FAIL b2b_idle: got %0d want IDLE", dut.state_q); end
      n_checks++; if (dut.last_q !== 1'b1) begin n_fail++; $display("FAIL b2b_last1: got %b want 1", dut.last_q); end
      req1 = 1; we1 = 1; addr1 = 8'h10; wdata1 = 8'hFF;
      next_cycle();
      req1 = 0; #1;
      n_checks++; if ({gnt1, mem_we} !== 2'b00) begin n_fail++; $display("FAIL b2b_early_drop: got %b want 00", {gnt1, mem_we}); end
      next_cycle(); #1;
      n_checks++; if (rvalid1 !== 1'b0) begin n_fail++; $display("FAIL b2b_early_rvalid: got %b want 0", rvalid1); end
      n_checks++; if (ram[8'h10] !== 8'hA5) begin n_fail++; $display("FAIL b2b_early_ram: got %h want a5", ram[8'h10]); end
      clear_inputs();
   endtask

   task automatic test_mid_reset();
      do_reset();
      req1 = 1; we1 = 0; addr1 = 8'h10;
      next_cycle(); #1;
      n_checks++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL mr_gnt1: got %b want 1", gnt1); end
      next_cycle();
      rst = 0; we1 = 1; wdata1 = 8'hEE; #1;
      n_checks++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL mr_rst_gnt1: got %b want 0", gnt1); end
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL mr_rst_mem_we: got %b want 0", mem_we); end
      next_cycle(); #1;
      n_checks++; if (rvalid1 !== 1'b0) begin n_fail++; $display("FAIL mr_rvalid1: got %b want 0", rvalid1); end
      n_checks++; if (dut.state_q !== ARB_IDLE) begin n_fail++; $display("FAIL mr_state: got %0d want IDLE", dut.state_q); end
      n_checks++; if (ram[8'h10] !== 8'hA5) begin n_fail++; $display("FAIL mr_ram: got %h want a5", ram[8'h10]); end
      clear_inputs();
      rst = 1;
      next_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_read();
      test_tie();
      test_fairness();
      test_solo_burst();
      test_back_to_back();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
